// File: rtl/dp_controller.sv
// Instruction sequencer for the 16x16 register-file/ALU datapath; optional illegal-class trap under CTRL_ILLEGAL_TRAP_EN.
// Latency: one FETCH cycle plus one EXEC cycle per instruction; LOAD/STORE add wait cycles until their handshake completes.
// Backpressure: instr_ready only in FETCH (single instruction in flight, no skid); WAIT_IN/WAIT_OUT stall indefinitely on in_valid/out_ready.
module dp_controller #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int OP_W    = 4,
  parameter int INSTR_W = 4 + OP_W + 3 * REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               z,
  output logic [REG_AW-1:0]  a_sel,
  output logic [REG_AW-1:0]  b_sel,
  output logic [OP_W-1:0]    op_sel,
  output logic [REG_AW-1:0]  dest_sel,
  output logic [DATA_W-1:0]  const_out,
  output logic               const_sel,
  output logic               data_sel,
  output logic               load_en,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               halted,
  output logic               err
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_HALTED
  } state_t;

  localparam logic [3:0] CLS_NOP   = 4'd0;
  localparam logic [3:0] CLS_ALURR = 4'd1;
  localparam logic [3:0] CLS_ALURI = 4'd2;
  localparam logic [3:0] CLS_LOAD  = 4'd3;
  localparam logic [3:0] CLS_STORE = 4'd4;
  localparam logic [3:0] CLS_SKIPZ = 4'd5;
  localparam logic [3:0] CLS_HALT  = 4'd6;

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic               skip, skip_nxt;

  // Instruction fields: {cls, op, dst, ra, rb}
  logic [3:0]        cls;
  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] dst, ra, rb;

  assign cls = ir[INSTR_W-1 -: 4];
  assign op  = ir[3*REG_AW +: OP_W];
  assign dst = ir[2*REG_AW +: REG_AW];
  assign ra  = ir[REG_AW +: REG_AW];
  assign rb  = ir[0 +: REG_AW];

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic err_q, err_nxt;
  assign err = err_q & rst_n;
`else
  assign err = 1'b0;
`endif

  // State, instruction register and skip flag; ir only changes on an accepted instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ir    <= '0;
      skip  <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
`ifdef CTRL_ILLEGAL_TRAP_EN
      err_q <= err_nxt;
`endif
      if (state == S_FETCH && instr_valid) begin
        ir <= instr_in;
      end
    end
  end

  // Next-state and datapath control decode from {state, ir}; everything forced inactive while in reset
  always_comb begin
    state_nxt   = state;
    skip_nxt    = skip;
`ifdef CTRL_ILLEGAL_TRAP_EN
    err_nxt     = err_q;
`endif
    instr_ready = 1'b0;
    a_sel       = ra;
    b_sel       = rb;
    op_sel      = op;
    dest_sel    = dst;
    const_out   = {{(DATA_W-REG_AW){1'b0}}, rb};
    const_sel   = 1'b0;
    data_sel    = 1'b0;
    load_en     = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    halted      = 1'b0;

    case (state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (skip) begin
          // Skipped instruction runs as NOP whatever its class, and does not re-arm skip
          skip_nxt = 1'b0;
        end else begin
          case (cls)
            CLS_NOP:   ;
            CLS_ALURR: load_en = 1'b1;
            CLS_ALURI: begin
              const_sel = 1'b1;
              load_en   = 1'b1;
            end
            CLS_LOAD:  state_nxt = S_WAIT_IN;
            CLS_STORE: state_nxt = S_WAIT_OUT;
            CLS_SKIPZ: skip_nxt = z;
            CLS_HALT:  state_nxt = S_HALTED;
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              state_nxt = S_HALTED;
              err_nxt   = 1'b1;
`endif
            end
          endcase
        end
      end
      S_WAIT_IN: begin
        data_sel = 1'b1;
        in_ready = 1'b1;
        load_en  = in_valid;
        if (in_valid) begin
          state_nxt = S_FETCH;
        end
      end
      S_WAIT_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_FETCH;
        end
      end
      S_HALTED: halted = 1'b1;
      default:  state_nxt = S_FETCH;
    endcase

    if (!rst_n) begin
      instr_ready = 1'b0;
      a_sel       = '0;
      b_sel       = '0;
      op_sel      = '0;
      dest_sel    = '0;
      const_out   = '0;
      const_sel   = 1'b0;
      data_sel    = 1'b0;
      load_en     = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_dp_controller.sv
// Directed bench for dp_controller: reset, ALU rr/ri, LOAD/STORE handshakes, SKIPZ, HALT, illegal class.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// No backpressure of its own; waits are fixed cycle counts with a global watchdog.
module tb_dp_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        z;
  logic [3:0]  a_sel, b_sel, op_sel, dest_sel;
  logic [15:0] const_out;
  logic        const_sel, data_sel, load_en;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        halted, err;

  int checks = 0;
  int errors = 0;

  dp_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .z           (z),
    .a_sel       (a_sel),
    .b_sel       (b_sel),
    .op_sel      (op_sel),
    .dest_sel    (dest_sel),
    .const_out   (const_out),
    .const_sel   (const_sel),
    .data_sel    (data_sel),
    .load_en     (load_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b1; instr_in = 20'h13527;
    z = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({instr_ready, load_en, halted, err, in_ready, out_valid} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctrl cycle %0d: got rdy/ld/halt/err/inr/outv=%b want 000000", i,
                 {instr_ready, load_en, halted, err, in_ready, out_valid});
      end
      checks++;
      if ({a_sel, b_sel, op_sel, dest_sel, const_out, const_sel, data_sel} !== 34'b0) begin
        errors++;
        $display("FAIL reset_sel cycle %0d: got a=%h b=%h op=%h d=%h c=%h want all 0", i,
                 a_sel, b_sel, op_sel, dest_sel, const_out);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_accept: instr_ready=%b want 1", instr_ready);
    end
  endtask

  task automatic test_alu_rr();
    instr_in = 20'h13527; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    #1;
    checks++;
    if ({op_sel, dest_sel, a_sel, b_sel, const_sel, load_en, instr_ready} !== {4'h3, 4'h5, 4'h2, 4'h7, 3'b010}) begin
      errors++;
      $display("FAIL alu_rr_exec: op=%h d=%h a=%h b=%h cs=%b ld=%b rdy=%b want 3 5 2 7 0 1 0",
               op_sel, dest_sel, a_sel, b_sel, const_sel, load_en, instr_ready);
    end
    tick();
    checks++;
    if ({load_en, instr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL alu_rr_done: ld=%b rdy=%b want 0 1", load_en, instr_ready);
    end
  endtask

  task automatic test_back_to_back();
    instr_in = 20'h11234; instr_valid = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({instr_ready, load_en} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL b2b cycle %0d: rdy=%b ld=%b want %b", i, instr_ready, load_en,
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_alu_ri();
    instr_in = 20'h2011F; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    #1;
    checks++;
    if ({const_sel, const_out, load_en, dest_sel, data_sel} !== {1'b1, 16'h000F, 1'b1, 4'h1, 1'b0}) begin
      errors++;
      $display("FAIL alu_ri_exec: cs=%b c=%h ld=%b d=%h ds=%b want 1 000f 1 1 0",
               const_sel, const_out, load_en, dest_sel, data_sel);
    end
    tick();
  endtask

  task automatic test_load();
    instr_in = 20'h30400; instr_valid = 1'b1; in_valid = 1'b0;
    tick();
    instr_valid = 1'b0;
    #1;
    checks++;
    if ({load_en, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL load_exec: ld=%b inr=%b want 0 0", load_en, in_ready);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready, load_en, data_sel} !== 3'b101) begin
        errors++;
        $display("FAIL load_wait cycle %0d: inr=%b ld=%b ds=%b want 1 0 1", i, in_ready, load_en, data_sel);
      end
      tick();
    end
    in_valid = 1'b1;
    #1;
    checks++;
    if ({load_en, data_sel, dest_sel} !== {1'b1, 1'b1, 4'h4}) begin
      errors++;
      $display("FAIL load_take: ld=%b ds=%b d=%h want 1 1 4", load_en, data_sel, dest_sel);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({load_en, in_ready, data_sel, instr_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL load_done: ld=%b inr=%b ds=%b rdy=%b want 0 0 0 1", load_en, in_ready, data_sel, instr_ready);
    end
  endtask

  task automatic test_store();
    instr_in = 20'h40060; instr_valid = 1'b1; out_ready = 1'b0;
    tick();
    instr_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, a_sel, load_en} !== {1'b1, 4'h6, 1'b0}) begin
        errors++;
        $display("FAIL store_wait cycle %0d: outv=%b a=%h ld=%b want 1 6 0", i, out_valid, a_sel, load_en);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL store_take: outv=%b want 1", out_valid);
    end
    tick();
    out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, instr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL store_done: outv=%b rdy=%b want 0 1", out_valid, instr_ready);
    end
  endtask

  task automatic test_skipz();
    // z=1: following LOAD is dropped even though in_valid is high
    instr_in = 20'h50012; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; z = 1'b1;
    #1;
    checks++;
    if ({load_en, const_sel, op_sel, a_sel, b_sel} !== {2'b00, 4'h0, 4'h1, 4'h2}) begin
      errors++;
      $display("FAIL skipz_exec: ld=%b cs=%b op=%h a=%h b=%h want 0 0 0 1 2", load_en, const_sel, op_sel, a_sel, b_sel);
    end
    tick();
    z = 1'b0; in_valid = 1'b1;
    instr_in = 20'h30400; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, load_en} !== 2'b00) begin
      errors++;
      $display("FAIL skip_load_exec: inr=%b ld=%b want 0 0", in_ready, load_en);
    end
    tick();
    checks++;
    if ({in_ready, load_en, instr_ready} !== 3'b001) begin
      errors++;
      $display("FAIL skip_load_after: inr=%b ld=%b rdy=%b want 0 0 1", in_ready, load_en, instr_ready);
    end
    in_valid = 1'b0;
    // z=0: following ALU writes normally
    instr_in = 20'h50000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; z = 1'b0;
    tick();
    instr_in = 20'h10312; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    #1;
    checks++;
    if ({load_en, dest_sel} !== {1'b1, 4'h3}) begin
      errors++;
      $display("FAIL noskip_alu: ld=%b d=%h want 1 3", load_en, dest_sel);
    end
    tick();
  endtask

  task automatic test_halt();
    instr_in = 20'h60000; instr_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({halted, instr_ready, err} !== 3'b100) begin
        errors++;
        $display("FAIL halt cycle %0d: halted=%b rdy=%b err=%b want 1 0 0", i, halted, instr_ready, err);
      end
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({halted, instr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL halt_reset: halted=%b rdy=%b want 0 1", halted, instr_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    instr_in = 20'h30400; instr_valid = 1'b1; in_valid = 1'b0;
    tick();
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b0; in_valid = 1'b1;
    #1;
    checks++;
    if ({load_en, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_load: ld=%b inr=%b want 0 0", load_en, in_ready);
    end
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if ({instr_ready, load_en, in_ready} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_load_after: rdy=%b ld=%b inr=%b want 1 0 0", instr_ready, load_en, in_ready);
    end
  endtask

  task automatic test_illegal();
    instr_in = 20'h90000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    #1;
    checks++;
    if (load_en !== 1'b0) begin
      errors++;
      $display("FAIL illegal_exec: ld=%b want 0", load_en);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if ({halted, err, instr_ready} !== 3'b110) begin
        errors++;
        $display("FAIL illegal_trap cycle %0d: halted=%b err=%b rdy=%b want 1 1 0", i, halted, err, instr_ready);
      end
`else
      if ({halted, err, instr_ready} !== 3'b001) begin
        errors++;
        $display("FAIL illegal_nop cycle %0d: halted=%b err=%b rdy=%b want 0 0 1", i, halted, err, instr_ready);
      end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_rr();
    test_back_to_back();
    test_alu_ri();
    test_load();
    test_store();
    test_skipz();
    test_halt();
    test_reset_mid_load();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
